// File: rtl/dff_debounce.sv
// rtl/dff_debounce.sv - debounce and edge-detect stage for the dff Q output
module dff_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic             q,
    output logic             qb,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy
);

    localparam logic [1:0] S_LOW   = 2'd0;
    localparam logic [1:0] S_CHK_H = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_CHK_L = 2'd3;

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic       d_r;
    logic [1:0] state;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    // Count holds at the limit rather than wrapping.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt != STABLE_LIM) begin
            cnt_nxt = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r      <= 1'b0;
            state    <= S_LOW;
            cnt      <= 8'd0;
            q        <= 1'b0;
            qb       <= 1'b1;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            d_r  <= d;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                S_LOW: begin
                    if (d_r) begin
                        state <= S_CHK_H;
                        cnt   <= 8'd1;
                    end
                end
                S_CHK_H: begin
                    if (!d_r) begin
                        state <= S_LOW;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == STABLE_LIM) begin
                            state    <= S_HIGH;
                            q        <= 1'b1;
                            qb       <= 1'b0;
                            rise     <= 1'b1;
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (!d_r) begin
                        state <= S_CHK_L;
                        cnt   <= 8'd1;
                    end
                end
                default: begin
                    if (d_r) begin
                        state <= S_HIGH;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == STABLE_LIM) begin
                            state    <= S_LOW;
                            q        <= 1'b0;
                            qb       <= 1'b1;
                            fall     <= 1'b1;
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_CHK_H) || (state == S_CHK_L);

endmodule

// File: tb/tb_dff_debounce.sv
// tb/tb_dff_debounce.sv - scoreboard bench for dff_debounce
module tb_dff_debounce;

    localparam int SC = 4;

    logic       clk;
    logic       rst;
    logic       d;
    logic       q;
    logic       qb;
    logic       rise;
    logic       fall;
    logic [7:0] edge_cnt;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       q;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    // Reference: count consecutive registered samples that disagree with q.
    logic       m_dr  = 1'b0;
    logic       m_q   = 1'b0;
    int         m_run = 0;
    logic [7:0] m_ec  = 8'd0;

    dff_debounce #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .d        (d),
        .q        (q),
        .qb       (qb),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic dv, input logic rv);
        exp_t e;
        @(negedge clk);
        d   = dv;
        rst = rv;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (rv) begin
            m_dr  = 1'b0;
            m_q   = 1'b0;
            m_run = 0;
            m_ec  = 8'd0;
        end else begin
            if (m_dr !== m_q) begin
                m_run++;
                if (m_run == SC) begin
                    m_q   = ~m_q;
                    m_run = 0;
                    m_ec  = m_ec + 8'd1;
                    if (m_q) e.rise = 1'b1;
                    else     e.fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_dr = dv;
        end
        e.q    = m_q;
        e.busy = (m_run != 0);
        e.ec   = m_ec;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.q || qb !== ~e.q || rise !== e.rise || fall !== e.fall ||
                busy !== e.busy || edge_cnt !== e.ec) begin
                failures++;
                $display("FAIL scoreboard t=%0t got q=%b qb=%b rise=%b fall=%b busy=%b edge_cnt=%0d want q=%b qb=%b rise=%b fall=%b busy=%b edge_cnt=%0d",
                         $time, q, qb, rise, fall, busy, edge_cnt,
                         e.q, ~e.q, e.rise, e.fall, e.busy, e.ec);
            end
        end
    end

    task automatic test_reset();
        int rise_at = 0;
        int nr = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            checks++;
            if (q !== 1'b0 || qb !== 1'b1 || edge_cnt !== 8'd0 || rise !== 1'b0 || fall !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got q=%b qb=%b edge_cnt=%0d rise=%b fall=%b want 0 1 0 0 0",
                         q, qb, edge_cnt, rise, fall);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            if (rise === 1'b1) begin
                nr++;
                if (rise_at == 0) rise_at = k;
            end
        end
        checks++;
        if (rise_at != 5 || nr != 1) begin
            failures++;
            $display("FAIL reset_release_rise got step=%0d count=%0d want step=5 count=1", rise_at, nr);
        end
        checks++;
        if (q !== 1'b1 || edge_cnt !== 8'd1) begin
            failures++;
            $display("FAIL reset_release_state got q=%b edge_cnt=%0d want q=1 edge_cnt=1", q, edge_cnt);
        end
    endtask

    task automatic test_glitch();
        int nb = 0;
        int nr = 0;
        logic [7:0] ec0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        ec0 = edge_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            if (busy === 1'b1) nb++;
            if (rise === 1'b1) nr++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            if (busy === 1'b1) nb++;
            if (rise === 1'b1) nr++;
        end
        checks++;
        if (nb != 3) begin
            failures++;
            $display("FAIL glitch_busy got %0d cycles want 3", nb);
        end
        checks++;
        if (nr != 0 || q !== 1'b0 || edge_cnt !== ec0) begin
            failures++;
            $display("FAIL glitch_reject got rises=%0d q=%b edge_cnt=%0d want 0 0 %0d", nr, q, edge_cnt, ec0);
        end
    endtask

    task automatic test_high_low();
        int rise_at = 0;
        int fall_at = 0;
        logic [7:0] ec0;
        ec0 = edge_cnt;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0);
            if (rise === 1'b1 && rise_at == 0) rise_at = k;
        end
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0);
            if (fall === 1'b1 && fall_at == 0) fall_at = k;
        end
        checks++;
        if (rise_at != 5 || fall_at != 5) begin
            failures++;
            $display("FAIL high_low_pulses got rise_step=%0d fall_step=%0d want 5 5", rise_at, fall_at);
        end
        checks++;
        if (edge_cnt !== ec0 + 8'd2) begin
            failures++;
            $display("FAIL high_low_count got %0d want %0d", edge_cnt, ec0 + 8'd2);
        end
    endtask

    task automatic test_toggle();
        int np = 0;
        int qchg = 0;
        logic q0;
        logic [7:0] ec0;
        q0  = q;
        ec0 = edge_cnt;
        for (int i = 0; i < 20; i++) begin
            step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
            if (rise === 1'b1 || fall === 1'b1) np++;
            if (q !== q0) qchg++;
        end
        checks++;
        if (np != 0 || qchg != 0 || edge_cnt !== ec0) begin
            failures++;
            $display("FAIL toggle got pulses=%0d q_changes=%0d edge_cnt=%0d want 0 0 %0d", np, qchg, edge_cnt, ec0);
        end
    endtask

    task automatic test_mid_reset();
        int rise_at = 0;
        int nr = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0 || edge_cnt !== 8'd0 || rise !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear got busy=%b edge_cnt=%0d rise=%b want 0 0 0", busy, edge_cnt, rise);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            if (rise === 1'b1) begin
                nr++;
                if (rise_at == 0) rise_at = k;
            end
        end
        checks++;
        if (rise_at != 5 || nr != 1 || edge_cnt !== 8'd1) begin
            failures++;
            $display("FAIL mid_reset_rise got step=%0d count=%0d edge_cnt=%0d want 5 1 1", rise_at, nr, edge_cnt);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        step(1'b0, 1'b1);
        for (int p = 0; p < 128; p++) begin
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 5; i++) begin
                    step((h == 0) ? 1'b1 : 1'b0, 1'b0);
                    if (rise === 1'b1 || fall === 1'b1) begin
                        n++;
                        if (n == 255) begin
                            checks++;
                            if (edge_cnt !== 8'd255) begin
                                failures++;
                                $display("FAIL wrap_255 got %0d want 255", edge_cnt);
                            end
                        end
                        if (n == 256) begin
                            checks++;
                            if (edge_cnt !== 8'd0) begin
                                failures++;
                                $display("FAIL wrap_0 got %0d want 0", edge_cnt);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (n != 256) begin
            failures++;
            $display("FAIL wrap_edges got %0d want 256", n);
        end
    endtask

    initial begin
        d   = 1'b1;
        rst = 1'b1;
        test_reset();
        test_glitch();
        test_high_low();
        test_toggle();
        test_mid_reset();
        test_wrap();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_debounce.md
# dff_debounce

Synchronous debounce and edge-detect stage that sits directly downstream of the `dff` cell and consumes its `Q` output. It accepts a level change only after the input has been stable for a programmable number of clock cycles. It then publishes a clean level with its complement, single-cycle rise and fall pulses, and a running count of accepted edges. Short glitches on the `dff` output are absorbed here and never reach later logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical input samples required to accept a level change; legal range 2..255.
- `CNT_W`, default 8: width of the accepted-edge counter.

- `clk`  in  1  rising-edge clock, shared with the upstream `dff`.
- `rst`  in  1  synchronous, active-high reset.
- `d`  in  1  raw level, driven by the `dff` `Q` output.
- `q`  out  1  debounced level.
- `qb`  out  1  always `~q`, registered alongside `q`.
- `rise`  out  1  one-cycle pulse when `q` goes 0->1.
- `fall`  out  1  one-cycle pulse when `q` goes 1->0.
- `edge_cnt`  out  CNT_W  number of accepted edges (rise plus fall), modulo 2^CNT_W.
- `busy`  out  1  high while a candidate change is being qualified.

## Operation
- Input register `d_r` captures `d` on every edge. There is no extra synchronizer, because `d` is already in the `clk` domain.
- Stability counter `cnt` is 8 bits and saturates at `STABLE_CYCLES`.
- Four FSM states, all transitions on the `clk` rising edge:
  - `S_LOW`: `q`=0. If `d_r`=1, go to `S_CHK_H` with `cnt`=1.
  - `S_CHK_H`: if `d_r`=0, return to `S_LOW` and clear `cnt` (glitch rejected). Otherwise `cnt`+1. When `cnt`+1 == `STABLE_CYCLES`, go to `S_HIGH`, set `q`=1 and `qb`=0, pulse `rise`, and increment `edge_cnt`.
  - `S_HIGH`: `q`=1. If `d_r`=0, go to `S_CHK_L` with `cnt`=1.
  - `S_CHK_L`: mirror of `S_CHK_H` with opposite polarity. On acceptance go to `S_LOW`, set `q`=0 and `qb`=1, pulse `fall`, and increment `edge_cnt`.
- `busy` = state is `S_CHK_H` or `S_CHK_L`. It is a registered-state decode with no combinational path from `d`.
- `rise` and `fall` are mutually exclusive and each is high for exactly one cycle per accepted edge. Back-to-back pulses of the same kind are impossible.
- `edge_cnt` wraps from 2^CNT_W-1 to 0 silently, with no flag.
- Reset values: `d_r`=0, state `S_LOW`, `cnt`=0, `q`=0, `qb`=1, `rise`=0, `fall`=0, `edge_cnt`=0, `busy`=0.
- `rst` dominates all other activity. Asserting it mid-qualification abandons the candidate: no pulse is generated and `edge_cnt` is left at 0 because reset clears it.
- If `d`=1 during reset, the post-reset behaviour is a normal rising qualification that starts from the first sample after `rst` deasserts.

## Timing
- Let N be the first edge at which `d` is sampled 1 while the block is in `S_LOW`.
  - If `d` is sampled 1 at edges N..N+STABLE_CYCLES-1, then `q`, `qb`, `rise` and `edge_cnt` update at edge N+STABLE_CYCLES.
  - Latency from `d` change to `q` change is `STABLE_CYCLES` cycles. The same applies to falling edges.
- `busy` rises at edge N+1 and falls at edge N+STABLE_CYCLES, or at the edge after a rejecting sample.
- A low sample at any edge N+1..N+STABLE_CYCLES-1 returns the FSM to `S_LOW` one edge later, with `q` unchanged.
- An input toggling every cycle is never accepted, and `q` stays constant.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `CNT_W`=8.
- Reset held 3 cycles with `d`=1, then released. During reset: `q`=0, `qb`=1, `edge_cnt`=0, no pulses. After release: `q`=1 and a single `rise` at the 4th edge after the first post-reset sample, `edge_cnt`=1.
- From `S_LOW`, `d` high for 3 cycles, then low. `busy` is high for 3 cycles, `q` stays 0, no `rise`, `edge_cnt` stays 0.
- `d` high 6 cycles, then low 6 cycles. `rise` at edge N+4; `fall` 4 edges after the first low sample; `edge_cnt`=2; `qb`==~`q` every cycle.
- `d` toggling every cycle for 20 cycles. `q` constant, `rise` and `fall` never asserted, `edge_cnt` unchanged.
- `d` high 2 cycles, then `rst` asserted for 1 cycle while `d` stays high. The FSM restarts qualification after reset; exactly one `rise`, at 4 edges after the first post-reset sample; `edge_cnt`=1.
- 256 clean accepted edges (128 high/low pairs of 5 cycles each). `edge_cnt` reads 255 after the 255th edge and wraps to 0 on the 256th.
